fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS pipeline. It sits directly upstream of the instruction memory: it owns the program counter, drives the word-aligned fetch address, and captures the returned instruction together with PC+4 into the IF/ID pipeline register for the decode stage. It applies stall, flush and redirect (branch/jump/jr) control from the hazard and branch logic.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 1025, depth of instruction memory in words; fetches at word index ≥ IMEM_WORDS are out of range.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC and IF/ID contents this cycle.
- Flush  in  1  replace IF/ID contents with a bubble this cycle.
- Redirect  in  1  load PC from RedirectTarget (taken branch, j, jal, jr).
- RedirectTarget  in  32  new PC; bits [1:0] are ignored.
- Instruction  in  32  instruction memory read data for InstrAddress, valid in the same cycle.
- InstrAddress  out  32  current PC, to instruction memory.
- IFID_Instruction  out  32  registered instruction for decode.
- IFID_PCPlus4  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  IF/ID holds a real instruction, not a bubble.
- MisalignErr  out  1  sticky: a redirect target had nonzero bits [1:0].
- FetchCount  out  32  number of valid instructions loaded into IF/ID; saturating.

## Operation

- InstrAddress = PC, driven directly from the PC register with no combinational path from any input.
- PC update on every rising edge, in priority order:
  - Redirect=1: PC ← {RedirectTarget[31:2], 2'b00}. This overrides Stall.
  - else Stall=1: PC holds.
  - else: PC ← PC + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update on every rising edge, in priority order:
  - Redirect=1 or Flush=1: load a bubble. Instruction ← 32'h0000_0000 (NOP), PCPlus4 ← 0, Valid ← 0.
  - else Stall=1: hold all three fields.
  - else if (PC>>2) ≥ IMEM_WORDS: load a bubble and leave PC advancing normally.
  - else: Instruction ← Instruction input, PCPlus4 ← PC+4, Valid ← 1.
- Simultaneous Flush and Stall: the bubble is loaded and PC holds.
- MisalignErr is set on any edge where Redirect=1 and RedirectTarget[1:0]≠0. It is cleared only by Reset.
- FetchCount increments by 1 on each edge where IF/ID loads with Valid ← 1, and saturates at 32'hFFFF_FFFF.

## Timing

- Reset asserted (asynchronous, at any time including mid-redirect): PC = RESET_PC, IFID_Instruction = 0, IFID_PCPlus4 = 0, IFID_Valid = 0, MisalignErr = 0, FetchCount = 0.
- First edge after Reset deasserts: IF/ID captures mem[RESET_PC>>2] with PCPlus4 = RESET_PC+4.
- Fetch latency is 1 cycle: address N is presented in cycle t, and its instruction appears on IFID_* after the edge ending cycle t.
- Redirect penalty is 1 bubble. On the redirect edge IF/ID becomes a bubble, and the target instruction reaches IF/ID on the following edge.
- Throughput is one instruction per cycle when Stall=0.
- Inputs are sampled only at the rising edge; there is no handshake beyond Stall.

## Structure

- Shared package mips_fetch_pkg holds:
  - constant NOP_INSTR = 32'h0000_0000;
  - constant PC_INCR = 4;
  - the default RESET_PC;
  - a struct typedef for the IF/ID bundle {instruction, pc_plus4, valid}.
- One sub-module, if_id_reg. It is the IF/ID pipeline register with load, hold and bubble controls, and it is reused as the pattern for later pipeline registers.
- PC register, next-PC mux, range check, MisalignErr and FetchCount live in fetch_stage.

## Test plan

- Reset then 4 free-running cycles, with mem words 0–3 = 0x20080001, 0x20090002, 0x01095020, 0xAC0A0000 → InstrAddress steps 0, 4, 8, 12, and IF/ID shows each word with PCPlus4 = 4, 8, 12, 16, Valid=1, FetchCount=4.
- Stall held 2 cycles at PC=8 → InstrAddress stays 8, IF/ID holds 0x20090002/8, FetchCount does not change; release → 0x01095020/12 loads.
- Redirect=1 with target 0x40 while Stall=1 → PC=0x40, IF/ID bubble (Valid=0, Instruction=0), then mem[16] with PCPlus4=0x44 on the next edge.
- Redirect target 0x42 → PC=0x40 and MisalignErr=1; it stays 1 through 10 further cycles until Reset.
- Redirect to (IMEM_WORDS)*4 → IF/ID Valid=0 with NOP every cycle, and FetchCount frozen.
- Reset asserted asynchronously mid-cycle after 3 fetches → all outputs return to reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared constants and the IF/ID bundle type for the MIPS fetch stage.
package mips_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instruction: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline control in, instruction memory port, IF/ID outputs and status.
interface fetch_stage_if;

  logic        Stall;
  logic        Flush;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] Instruction;
  logic [31:0] InstrAddress;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        MisalignErr;
  logic [31:0] FetchCount;

  modport master (
    input  Stall, Flush, Redirect, RedirectTarget, Instruction,
    output InstrAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, MisalignErr, FetchCount
  );

  modport slave (
    output Stall, Flush, Redirect, RedirectTarget, Instruction,
    input  InstrAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, MisalignErr, FetchCount
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, load beats hold.
module if_id_reg
  import mips_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t ifid_q, ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (bubble) begin
      ifid_d = IFID_BUBBLE;
    end else if (load) begin
      ifid_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= IFID_BUBBLE;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, range check,
// misalignment flag and fetch counter, feeding the IF/ID register.
module fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = 1025
) (
  input logic           Clk,
  input logic           Reset,
  fetch_stage_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;
  logic [31:0] word_index;
  logic        in_range;
  logic        ifid_load;
  logic        ifid_bubble;
  logic        load_valid;
  ifid_t       ifid_next;
  ifid_t       ifid_q;

  assign pc_plus4   = pc_q + PC_INCR;
  assign word_index = {2'b00, pc_q[31:2]};
  assign in_range   = word_index < IMEM_WORDS;

  always_comb begin
    ifid_load   = !bus.Stall;
    ifid_bubble = bus.Redirect || bus.Flush || (!bus.Stall && !in_range);
    load_valid  = !bus.Redirect && !bus.Flush && !bus.Stall && in_range;

    ifid_next             = IFID_BUBBLE;
    ifid_next.instruction = bus.Instruction;
    ifid_next.pc_plus4    = pc_plus4;
    ifid_next.valid       = 1'b1;

    // Redirect wins over Stall so a taken branch is never lost behind a hazard.
    pc_d = pc_plus4;
    if (bus.Redirect) begin
      pc_d = {bus.RedirectTarget[31:2], 2'b00};
    end else if (bus.Stall) begin
      pc_d = pc_q;
    end

    misalign_d = misalign_q || (bus.Redirect && (bus.RedirectTarget[1:0] != 2'b00));

    fetch_count_d = fetch_count_q;
    if (load_valid && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q          <= RESET_PC;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk    (Clk),
    .rst_n  (Reset),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_next),
    .q      (ifid_q)
  );

  assign bus.InstrAddress     = pc_q;
  assign bus.IFID_Instruction = ifid_q.instruction;
  assign bus.IFID_PCPlus4     = ifid_q.pc_plus4;
  assign bus.IFID_Valid       = ifid_q.valid;
  assign bus.MisalignErr      = misalign_q;
  assign bus.FetchCount       = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random control traffic,
// all compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;
  import mips_fetch_pkg::*;

  localparam int unsigned IMEM_WORDS = 1025;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic Clk;
  logic Reset;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:IMEM_WORDS-1];
  logic [31:0] addrWord;

  // Instruction memory answers combinationally; out-of-range reads return junk the DUT must drop.
  always_comb begin
    addrWord = {2'b00, bus.InstrAddress[31:2]};
    if (addrWord < IMEM_WORDS) begin
      bus.Instruction = mem[addrWord[10:0]];
    end else begin
      bus.Instruction = 32'hDEAD_BEEF;
    end
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks;
  int failures;

  logic [31:0] mPc, mInstr, mPcPlus4, mCount;
  logic        mValid, mMis;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".addr"},  bus.InstrAddress,     mPc);
    checkOutput({tag, ".instr"}, bus.IFID_Instruction, mInstr);
    checkOutput({tag, ".pcp4"},  bus.IFID_PCPlus4,     mPcPlus4);
    checkOutput({tag, ".valid"}, {31'b0, bus.IFID_Valid},  {31'b0, mValid});
    checkOutput({tag, ".mis"},   {31'b0, bus.MisalignErr}, {31'b0, mMis});
    checkOutput({tag, ".count"}, bus.FetchCount,       mCount);
  endtask

  task automatic resetModel();
    mPc      = RESET_PC;
    mInstr   = 32'h0;
    mPcPlus4 = 32'h0;
    mValid   = 1'b0;
    mMis     = 1'b0;
    mCount   = 32'h0;
  endtask

  // Asserts reset right now (any phase), checks reset values before any edge, releases on the next negedge.
  task automatic doReset(input string tag);
    Reset = 1'b0;
    #1;
    resetModel();
    checkAll(tag);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  // Drives one cycle of control, advances the model by the fetch rules, checks after the edge.
  task automatic applyStimulus(input string tag, input logic stall, input logic flush,
                               input logic redirect, input logic [31:0] target);
    logic [31:0] nPc, nInstr, nPcPlus4, nCount;
    logic        nValid, nMis, inRange;
    bus.Stall          = stall;
    bus.Flush          = flush;
    bus.Redirect       = redirect;
    bus.RedirectTarget = target;

    inRange  = (mPc >> 2) < IMEM_WORDS;
    nInstr   = mInstr;
    nPcPlus4 = mPcPlus4;
    nValid   = mValid;
    nCount   = mCount;
    if (redirect || flush) begin
      nInstr = 32'h0; nPcPlus4 = 32'h0; nValid = 1'b0;
    end else if (!stall) begin
      if (inRange) begin
        nInstr   = mem[(mPc >> 2)];
        nPcPlus4 = mPc + 32'd4;
        nValid   = 1'b1;
        if (mCount != 32'hFFFF_FFFF) nCount = mCount + 32'd1;
      end else begin
        nInstr = 32'h0; nPcPlus4 = 32'h0; nValid = 1'b0;
      end
    end

    if (redirect)   nPc = target & 32'hFFFF_FFFC;
    else if (stall) nPc = mPc;
    else            nPc = mPc + 32'd4;

    nMis = mMis || (redirect && (target % 4 != 0));

    @(posedge Clk);
    #1;
    mPc = nPc; mInstr = nInstr; mPcPlus4 = nPcPlus4; mValid = nValid; mMis = nMis; mCount = nCount;
    checkAll(tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  logic [31:0] tgt;
  int          sel;

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'hAC0A_0000;
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.Redirect = 1'b0; bus.RedirectTarget = 32'h0;

    doReset("reset");
    for (int i = 0; i < 4; i++) applyStimulus("free", 1'b0, 1'b0, 1'b0, 32'h0);

    doReset("reset2");
    applyStimulus("pre_stall", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("pre_stall", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("stall", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("stall", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("release", 1'b0, 1'b0, 1'b0, 32'h0);

    applyStimulus("redir_stall", 1'b1, 1'b0, 1'b1, 32'h0000_0040);
    applyStimulus("redir_tgt", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("flush_stall", 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus("flush", 1'b0, 1'b1, 1'b0, 32'h0);

    applyStimulus("misalign", 1'b0, 1'b0, 1'b1, 32'h0000_0042);
    for (int i = 0; i < 10; i++) applyStimulus("mis_sticky", 1'b0, 1'b0, 1'b0, 32'h0);
    doReset("mis_reset");

    applyStimulus("oor_redir", 1'b0, 1'b0, 1'b1, IMEM_WORDS * 4);
    for (int i = 0; i < 4; i++) applyStimulus("oor_free", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("last_word", 1'b0, 1'b0, 1'b1, (IMEM_WORDS - 1) * 4);
    applyStimulus("last_word", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("wrap_redir", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) applyStimulus("wrap", 1'b0, 1'b0, 1'b0, 32'h0);

    doReset("reset3");
    for (int i = 0; i < 3; i++) applyStimulus("pre_async", 1'b0, 1'b0, 1'b0, 32'h0);
    bus.Redirect = 1'b1; bus.RedirectTarget = 32'h0000_0100;
    #2;
    bus.Redirect = 1'b0;
    doReset("async_reset");

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       tgt = 32'hFFFF_FFF0 | ($urandom_range(0, 3) * 4);
        1:       tgt = (IMEM_WORDS + $urandom_range(0, 3)) * 4;
        2:       tgt = ($urandom_range(0, IMEM_WORDS - 1) * 4) | $urandom_range(1, 3);
        default: tgt = $urandom_range(0, IMEM_WORDS - 1) * 4;
      endcase
      applyStimulus("random", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0), tgt);
      if (i % 100 == 99) doReset("random_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
